// File: rtl/rs232_pkg.sv
// Shared types and constants for the RS232 receiver: FSM state encoding,
// default clock/baud values and the bit-period divisor helper.
package rs232_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rs232_state_e;

  localparam int unsigned CLOCK_FREQ_DEF = 50_000_000;
  localparam int unsigned BAUD_FAST_DEF  = 115_200;
  localparam int unsigned BAUD_SLOW_DEF  = 9_600;

  // Clock cycles per bit; integer division truncates.
  function automatic int unsigned div_of(input int unsigned clock_freq,
                                         input int unsigned baud);
    return clock_freq / baud;
  endfunction

  localparam int unsigned CNT_W_DEF = $clog2(div_of(CLOCK_FREQ_DEF, BAUD_SLOW_DEF));

endpackage

// File: rtl/rs232_rx_sync.sv
// Two-flop synchroniser for rxd plus the sample-value path. With
// RS232_RX_MAJORITY_EN defined the sample is a 2-of-3 vote over the last three rxd_s values.
module rs232_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rxd_i,
  output logic rxd_s_o,
  output logic sample_val_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= rxd_i;
      sync_q <= meta_q;
    end
  end

  assign rxd_s_o = sync_q;

`ifdef RS232_RX_MAJORITY_EN
  logic hist1_q;
  logic hist2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist1_q <= 1'b1;
      hist2_q <= 1'b1;
    end else begin
      hist1_q <= sync_q;
      hist2_q <= hist1_q;
    end
  end

  // Vote is combinational on registered history, so sample latency is unchanged.
  assign sample_val_o = (sync_q & hist1_q) | (sync_q & hist2_q) | (hist1_q & hist2_q);
`else
  assign sample_val_o = sync_q;
`endif

endmodule

// File: rtl/rs232_rx.sv
// RS232 8N1 receiver: start-edge detect, mid-bit sampling, LSB-first shift,
// stop-bit check. Optional majority sampling via RS232_RX_MAJORITY_EN.
module rs232_rx
  import rs232_pkg::*;
#(
  parameter int unsigned clock_freq = CLOCK_FREQ_DEF,
  parameter int unsigned baud_fast  = BAUD_FAST_DEF,
  parameter int unsigned baud_slow  = BAUD_SLOW_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fsel,
  input  logic         rxd,
  output logic [7:0]   data,
  output logic         rdy,
  output logic         ferr,
  output rs232_state_e state_dbg
);

  localparam int unsigned DIV_FAST = div_of(clock_freq, baud_fast);
  localparam int unsigned DIV_SLOW = div_of(clock_freq, baud_slow);
  localparam int unsigned CNT_W    = $clog2(DIV_SLOW);

  localparam logic [CNT_W-1:0] FULL_FAST = CNT_W'(DIV_FAST - 1);
  localparam logic [CNT_W-1:0] FULL_SLOW = CNT_W'(DIV_SLOW - 1);
  localparam logic [CNT_W-1:0] HALF_FAST = CNT_W'(DIV_FAST / 2 - 1);
  localparam logic [CNT_W-1:0] HALF_SLOW = CNT_W'(DIV_SLOW / 2 - 1);

  logic rxd_s;
  logic sample_val;

  rs232_rx_sync u_sync (
    .clk          (clk),
    .rst          (rst),
    .rxd_i        (rxd),
    .rxd_s_o      (rxd_s),
    .sample_val_o (sample_val)
  );

  rs232_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       data_q, data_d;
  logic             rdy_q, rdy_d;
  logic             ferr_q, ferr_d;

  logic [CNT_W-1:0] full_ld;
  logic [CNT_W-1:0] half_ld;
  logic             expired;

  // fsel only matters at the moment a reload value is taken.
  always_comb begin
    full_ld = fsel ? FULL_SLOW : FULL_FAST;
    half_ld = fsel ? HALF_SLOW : HALF_FAST;
    expired = (cnt_q == '0);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    data_d   = data_q;
    rdy_d    = 1'b0;
    ferr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rxd_s) begin
          state_d = START;
          cnt_d   = half_ld;
        end
      end
      START: begin
        if (expired) begin
          if (!sample_val) begin
            state_d  = DATA;
            bitcnt_d = 3'd0;
            cnt_d    = full_ld;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DATA: begin
        if (expired) begin
          shreg_d  = {sample_val, shreg_q[7:1]};
          cnt_d    = full_ld;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STOP: begin
        if (expired) begin
          if (sample_val) begin
            data_d  = shreg_q;
            rdy_d   = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      BREAK: begin
        // A line held low must rise before another frame can start.
        if (rxd_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bitcnt_q <= 3'd0;
      shreg_q  <= 8'h00;
      data_q   <= 8'h00;
      rdy_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      data_q   <= data_d;
      rdy_q    <= rdy_d;
      ferr_q   <= ferr_d;
    end
  end

  // rdy/ferr are one-cycle strobes with no ready: the consumer takes data in the rdy cycle.
  assign data      = data_q;
  assign rdy       = rdy_q;
  assign ferr      = ferr_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_rs232_rx.sv
// Directed bench for rs232_rx at 1.152 MHz (div 10 fast, 120 slow); strobes
// are checked against an expected queue of {is_ferr, data} entries.
`timescale 1ns/1ps
module tb_rs232_rx;
  import rs232_pkg::*;

  localparam int unsigned CLK_F    = 1_152_000;
  localparam int          DIV_F    = 10;
  localparam int          DIV_S    = 120;
  localparam int          SYNC_LAT = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         fsel;
  logic         rxd;
  logic [7:0]   data;
  logic         rdy;
  logic         ferr;
  rs232_state_e state_dbg;

  rs232_rx #(
    .clock_freq (CLK_F),
    .baud_fast  (115_200),
    .baud_slow  (9_600)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fsel      (fsel),
    .rxd       (rxd),
    .data      (data),
    .rdy       (rdy),
    .ferr      (ferr),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int         errors = 0;
  int         checks = 0;
  logic [8:0] exp_q[$];
  logic [7:0] last_data = 8'h00;
  int         last_strobe_cyc = -1;
  int         start_cyc = 0;
  logic [8:0] mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rdy || ferr) begin
      check("strobe_exclusive", {31'b0, rdy & ferr}, 32'd0);
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_strobe: observed rdy=%0b ferr=%0b data=%0h expected no strobe",
               rdy, ferr, data);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("strobe_kind_ferr", {31'b0, ferr}, {31'b0, mon_e[8]});
        check("strobe_data", {24'b0, data}, {24'b0, mon_e[7:0]});
      end
      last_strobe_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input logic v, input int d, input int glitch_c);
    for (int c = 0; c < d; c++) begin
      @(posedge clk);
      #1 rxd = (c == glitch_c) ? 1'b1 : v;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int glitch_bit);
    int         d;
    logic [7:0] expd;
    d    = fsel ? DIV_S : DIV_F;
    expd = b;
`ifndef RS232_RX_MAJORITY_EN
    if (glitch_bit >= 0) expd[glitch_bit] = 1'b1;
`endif
    if (stop_v) begin
      exp_q.push_back({1'b0, expd});
      last_data = expd;
    end else begin
      exp_q.push_back({1'b1, last_data});
    end
    @(posedge clk);
    #1 rxd = 1'b0;
    start_cyc = cyc;
    for (int c = 1; c < d; c++) begin
      @(posedge clk);
      #1 rxd = 1'b0;
    end
    for (int k = 0; k < 8; k++) drive_bit(b[k], d, (k == glitch_bit) ? d / 2 : -1);
    drive_bit(stop_v, d, -1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check(tag, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int strobe_mark;
    rst  = 1'b1;
    fsel = 1'b0;
    rxd  = 1'b1;
    idle(3);
    check("reset_data", {24'b0, data}, 32'h00);
    check("reset_rdy", {31'b0, rdy}, 32'd0);
    check("reset_ferr", {31'b0, ferr}, 32'd0);
    check("reset_state", 32'(state_dbg), 32'(IDLE));
    rst = 1'b0;
    idle(5);

    // 1: single fast frame and its latency from the synchronised start edge
    send_frame(8'hA5, 1'b1, -1);
    wait_drain("t1_drain", 200);
    check("t1_data", {24'b0, data}, 32'hA5);
    lat = last_strobe_cyc - start_cyc - SYNC_LAT;
    check("t1_latency_window", {31'b0, (lat >= 93 && lat <= 97)}, 32'd1);
    idle(20);

    // 2: slow, back-to-back frames
    fsel = 1'b1;
    idle(2);
    send_frame(8'h3C, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    wait_drain("t2_drain", 2000);
    check("t2_data", {24'b0, data}, 32'hFF);
    fsel = 1'b0;
    idle(20);

    // 3: framing error, held-low line, then recovery
    send_frame(8'h55, 1'b0, -1);
    wait_drain("t3_ferr_drain", 200);
    check("t3_data_kept", {24'b0, data}, 32'hFF);
    strobe_mark = last_strobe_cyc;
    idle(150);
    check("t3_state_break", 32'(state_dbg), 32'(BREAK));
    idle(150);
    check("t3_no_frame_while_low", last_strobe_cyc, strobe_mark);
    rxd = 1'b1;
    idle(5);
    check("t3_state_idle_after_rise", 32'(state_dbg), 32'(IDLE));
    idle(10);
    send_frame(8'h01, 1'b1, -1);
    wait_drain("t3_drain", 200);
    check("t3_data_01", {24'b0, data}, 32'h01);
    idle(20);

    // 4: 3-cycle low glitch while idle is rejected at the half-bit point
    strobe_mark = last_strobe_cyc;
    @(posedge clk);
    #1 rxd = 1'b0;
    idle(3);
    rxd = 1'b1;
    check("t4_start_seen", 32'(state_dbg), 32'(START));
    idle(4);
    check("t4_still_start", 32'(state_dbg), 32'(START));
    idle(1);
    check("t4_back_idle", 32'(state_dbg), 32'(IDLE));
    idle(40);
    check("t4_no_strobe", last_strobe_cyc, strobe_mark);

    // 5: one-cycle high glitch at bit 3's sample instant of 8'h00
    send_frame(8'h00, 1'b1, 3);
    wait_drain("t5_drain", 200);
`ifdef RS232_RX_MAJORITY_EN
    check("t5_data_majority", {24'b0, data}, 32'h00);
`else
    check("t5_data_glitched", {24'b0, data}, 32'h08);
`endif
    idle(20);

    // 6: reset mid-byte of 8'hC3 (bits 1,1,0,...), then a clean 8'h7E
    strobe_mark = last_strobe_cyc;
    drive_bit(1'b0, DIV_F, -1);
    drive_bit(1'b1, DIV_F, -1);
    drive_bit(1'b1, DIV_F, -1);
    drive_bit(1'b0, 5, -1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    rxd = 1'b1;
    last_data = 8'h00;
    check("t6_rst_data", {24'b0, data}, 32'h00);
    check("t6_rst_state", 32'(state_dbg), 32'(IDLE));
    check("t6_rst_rdy", {31'b0, rdy}, 32'd0);
    idle(250);
    check("t6_no_strobe_aborted", last_strobe_cyc, strobe_mark);
    send_frame(8'h7E, 1'b1, -1);
    wait_drain("t6_drain", 200);
    check("t6_data", {24'b0, data}, 32'h7E);
    idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
